// File: rtl/core_pkg.sv
// Shared core constants: default register width, ABI register indices and the
// per-register scoreboard next-state rule.
package core_pkg;

  localparam int XLEN_DEF = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;
  localparam int REG_A0   = 10;

  // Next busy bit for one register. A new claim outranks a same-cycle
  // writeback, because the newly issued producer still owes a result.
  function automatic logic sb_next(input logic cur,
                                   input logic flush,
                                   input logic claim_hit,
                                   input logic wr_hit);
    if (flush)          return 1'b0;
    else if (claim_hit) return 1'b1;
    else if (wr_hit)    return 1'b0;
    else                return cur;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set by decode claims, cleared by writeback or a
// pipeline flush. Register 0 is never busy.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy_vec
);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec <= '0;
    end else begin
      busy_vec[REG_ZERO] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        busy_vec[r] <= sb_next(busy_vec[r], flush,
                               claim_en && (claim_addr == AW'(r)),
                               wr_en && (wr_addr == AW'(r)));
      end
    end
  end

endmodule

// File: rtl/regfile_scb.sv
// Integer register file with NRD combinational read ports, same-cycle write
// bypass, and a busy scoreboard for long-latency producers.
module regfile_scb
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs [NREGS];

  // Data write is independent of flush; only reset discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
      regs[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scb (
    .clk        (clk),
    .rst        (rst),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            is_zero;
    logic            wr_hit;
    logic [XLEN-1:0] data;

    assign addr    = rd_addr[k*AW +: AW];
    assign is_zero = (addr == AW'(REG_ZERO));
    assign wr_hit  = wr_en && (wr_addr == addr);

    always_comb begin
      data = regs[addr];
      if (is_zero)     data = '0;
      else if (wr_hit) data = wr_data;
    end

    assign rd_data[k*XLEN +: XLEN] = data;
    // A writeback landing this cycle both forwards the value and hides busy.
    assign rd_busy[k] = !is_zero && busy_vec[addr] && !wr_hit;
  end

endmodule

// File: tb/tb_regfile_scb.sv
// Directed self-checking bench for regfile_scb (NRD=3) with hand-computed
// expected values at each step.
module tb_regfile_scb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  int checks = 0;
  int errors = 0;

  regfile_scb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
    set_rd(5'd0, 5'd5, 5'd31);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("reset_rd0", rdd(0), 32'h0);
    chk("reset_rd1", rdd(1), 32'h0);
    chk("reset_rd2", rdd(2), 32'h0);
    chk("reset_busy", {29'b0, rd_busy}, 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);

    // x0 is hardwired: no bypass, no write
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
    #1;
    chk("x0_bypass", rdd(0), 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("x0_after_write", rdd(0), 32'h0);

    // Bypass on port 1, then registered value
    set_rd(5'd0, 5'd7, 5'd31);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
    #1;
    chk("x7_bypass", rdd(1), 32'h12345678);
    chk("x7_bypass_p2_other", rdd(2), 32'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("x7_stored", rdd(1), 32'h12345678);

    // Claim x3 at t, busy visible t+1..t+4, released by write at t+5
    set_rd(5'd3, 5'd7, 5'd3);
    claim_en = 1'b1; claim_addr = 5'd3;
    #1;
    chk("x3_busy_claim_cycle", {31'b0, rd_busy[0]}, 32'h0);
    tick();
    claim_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("x3_busy_t%0d", i), {31'b0, rd_busy[0]}, 32'h1);
      chk($sformatf("x3_busy_p2_t%0d", i), {31'b0, rd_busy[2]}, 32'h1);
      tick();
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
    #1;
    chk("x3_busy_hidden", {31'b0, rd_busy[0]}, 32'h0);
    chk("x3_fwd", rdd(0), 32'h000000A5);
    chk("x3_raw_still_busy", {31'b0, busy_vec[3]}, 32'h1);
    tick();
    wr_en = 1'b0;
    #1;
    chk("x3_released", {31'b0, busy_vec[3]}, 32'h0);
    chk("x3_stored", rdd(0), 32'h000000A5);

    // Same-cycle claim and write of x9: claim wins
    claim_en = 1'b1; claim_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    tick();
    claim_en = 1'b0; wr_en = 1'b0;
    set_rd(5'd0, 5'd0, 5'd9);
    #1;
    chk("x9_data", rdd(2), 32'h1);
    chk("x9_busy_vec", {31'b0, busy_vec[9]}, 32'h1);
    chk("x9_rd_busy", {31'b0, rd_busy[2]}, 32'h1);

    // Claim x4, x6; then flush with claim x8 and write x4
    claim_en = 1'b1; claim_addr = 5'd4;
    tick();
    claim_addr = 5'd6;
    tick();
    claim_en = 1'b0;
    #1;
    chk("pre_flush_busy_vec", busy_vec, 32'h0000_0250);
    set_rd(5'd4, 5'd6, 5'd8);
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd8;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
    #1;
    chk("flush_cycle_rd_busy", {29'b0, rd_busy}, 32'h2);
    tick();
    flush = 1'b0; claim_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("post_flush_busy_vec", busy_vec, 32'h0);
    chk("post_flush_x4", rdd(0), 32'h77);
    chk("post_flush_rd_busy", {29'b0, rd_busy}, 32'h0);

    // All ports on the same register
    set_rd(5'd4, 5'd4, 5'd4);
    #1;
    chk("same_reg_p0", rdd(0), 32'h77);
    chk("same_reg_p1", rdd(1), 32'h77);
    chk("same_reg_p2", rdd(2), 32'h77);

    // Claim x12 and write it, then reset mid-operation with a write to x2
    claim_en = 1'b1; claim_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h0000CAFE;
    tick();
    claim_en = 1'b0; wr_en = 1'b0;
    set_rd(5'd12, 5'd2, 5'd7);
    #1;
    chk("x12_busy_vec", busy_vec, 32'h0000_1000);
    chk("x12_data", rdd(0), 32'h0000CAFE);
    chk("x12_rd_busy", {31'b0, rd_busy[0]}, 32'h1);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    claim_en = 1'b1; claim_addr = 5'd2;
    #1;
    chk("rst_bypass_x2", rdd(1), 32'h55);
    tick();
    rst = 1'b0; wr_en = 1'b0; claim_en = 1'b0;
    #1;
    chk("post_rst_busy_vec", busy_vec, 32'h0);
    chk("post_rst_x12", rdd(0), 32'h0);
    chk("post_rst_x2", rdd(1), 32'h0);
    chk("post_rst_x7", rdd(2), 32'h0);
    chk("post_rst_rd_busy", {29'b0, rd_busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
